// File: rtl/cpu_fabianp1704_pkg.sv
// ---------------------------------------------------------------------------
// cpu_fabianp1704_pkg
// Shared definitions for the bit-serial 8-bit accumulator CPU:
//   - ALU opcode encodings
//   - manual debug-mux select encodings
//   - FSM state encodings
//   - flag bundle type and register-write decode helpers
// No ports (package).
// ---------------------------------------------------------------------------
package cpu_fabianp1704_pkg;

  // ALU opcodes; 13..15 are reserved and act as a no-op that still counts
  localparam logic [3:0] OP_ADD     = 4'd0;
  localparam logic [3:0] OP_SUB     = 4'd1;
  localparam logic [3:0] OP_AND     = 4'd2;
  localparam logic [3:0] OP_OR      = 4'd3;
  localparam logic [3:0] OP_XOR     = 4'd4;
  localparam logic [3:0] OP_PASS_A  = 4'd5;
  localparam logic [3:0] OP_PASS_B  = 4'd6;
  localparam logic [3:0] OP_SHL     = 4'd7;
  localparam logic [3:0] OP_SHR     = 4'd8;
  localparam logic [3:0] OP_MOVE_XA = 4'd9;
  localparam logic [3:0] OP_MOVE_AX = 4'd10;
  localparam logic [3:0] OP_INC     = 4'd11;
  localparam logic [3:0] OP_DEC     = 4'd12;

  // Debug mux selects; REG_B selects the X architectural register
  localparam logic [2:0] MUX_SELECT_ALU_Y = 3'd0;
  localparam logic [2:0] MUX_SELECT_REG_A = 3'd1;
  localparam logic [2:0] MUX_SELECT_REG_B = 3'd2;
  localparam logic [2:0] MUX_SELECT_OP    = 3'd3;
  localparam logic [2:0] MUX_SELECT_PC    = 3'd4;
  localparam logic [2:0] MUX_SELECT_NONE  = 3'd5;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD_A  = 3'd1;
  localparam logic [2:0] ST_LOAD_B  = 3'd2;
  localparam logic [2:0] ST_LOAD_OP = 3'd3;
  localparam logic [2:0] ST_EXEC    = 3'd4;
  localparam logic [2:0] ST_WB      = 3'd5;

  // Serial field lengths minus one (last-bit index of the bit counter)
  localparam logic [4:0] LAST_BIT_DATA = 5'd7;
  localparam logic [4:0] LAST_BIT_OP   = 5'd3;

  // Packed so that the 4-bit value is {N, V, Z, C}, matching uio_out[3:0]
  typedef struct packed {
    logic n;
    logic v;
    logic z;
    logic c;
  } flags_t;

  // Opcodes whose result lands in accumulator A
  function automatic logic op_writes_a(input logic [3:0] op);
    logic wr;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_PASS_A,
      OP_SHL, OP_SHR, OP_MOVE_AX, OP_INC, OP_DEC: wr = 1'b1;
      default:                                    wr = 1'b0;
    endcase
    return wr;
  endfunction

  // Opcodes whose result lands in index register X
  function automatic logic op_writes_x(input logic [3:0] op);
    logic wr;
    case (op)
      OP_PASS_B, OP_MOVE_XA: wr = 1'b1;
      default:               wr = 1'b0;
    endcase
    return wr;
  endfunction

endpackage

// File: rtl/cpu_fabianp1704_alu8.sv
// ---------------------------------------------------------------------------
// alu8
// Purely combinational 8-bit ALU for the accumulator CPU.
// Ports:
//   a, b  [7:0] in  : operands
//   op    [3:0] in  : opcode (see package)
//   y     [7:0] out : result
//   c, z, v, n  out : carry/borrow, zero, signed overflow, negative
// Reserved opcodes produce y=0 with every flag cleared (including Z).
// ---------------------------------------------------------------------------
module alu8
  import cpu_fabianp1704_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [3:0] op,
  output logic [7:0] y,
  output logic       c,
  output logic       z,
  output logic       v,
  output logic       n
);

  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [7:0] y_s;
  logic       c_s;
  logic       v_s;
  logic       valid_s;

  // 9-bit add/sub: bit 8 is carry-out for ADD and borrow (a<b) for SUB
  assign sum_s  = {1'b0, a} + {1'b0, b};
  assign diff_s = {1'b0, a} - {1'b0, b};

  // Opcode decode: result, carry and overflow
  always_comb begin
    y_s     = 8'h00;
    c_s     = 1'b0;
    v_s     = 1'b0;
    valid_s = 1'b1;
    case (op)
      OP_ADD: begin
        y_s = sum_s[7:0];
        c_s = sum_s[8];
        v_s = (a[7] == b[7]) && (sum_s[7] != a[7]);
      end
      OP_SUB: begin
        y_s = diff_s[7:0];
        c_s = diff_s[8];
        v_s = (a[7] != b[7]) && (diff_s[7] != a[7]);
      end
      OP_AND:     y_s = a & b;
      OP_OR:      y_s = a | b;
      OP_XOR:     y_s = a ^ b;
      OP_PASS_A:  y_s = a;
      OP_PASS_B:  y_s = b;
      OP_SHL: begin
        y_s = {a[6:0], 1'b0};
        c_s = a[7];
      end
      OP_SHR: begin
        y_s = {1'b0, a[7:1]};
        c_s = a[0];
      end
      OP_MOVE_XA: y_s = a;
      OP_MOVE_AX: y_s = b;
      OP_INC: begin
        y_s = a + 8'd1;
        c_s = (a == 8'hFF);
        v_s = (a == 8'h7F);
      end
      OP_DEC: begin
        y_s = a - 8'd1;
        c_s = (a == 8'h00);
        v_s = (a == 8'h80);
      end
      default: valid_s = 1'b0;
    endcase
  end

  assign y = y_s;
  assign c = c_s;
  assign v = v_s;
  // Reserved opcodes must report Z=0 even though y is zero
  assign z = valid_s & (y_s == 8'h00);
  assign n = y_s[7];

endmodule

// File: rtl/cpu_fabianp1704.sv
// ---------------------------------------------------------------------------
// cpu_fabianp1704
// Tiny Tapeout top: bit-serial front end feeding an 8-bit accumulator CPU.
// A start pulse in IDLE begins a transaction that shifts in A (8 bits),
// B (8 bits) and an opcode (4 bits), MSB first on ui_in[1]. EXEC latches the
// ALU result and flags; WB writes A or X and increments PC.
// Ports:
//   clk         in  : clock, rising-edge
//   rst_n       in  : asynchronous active-low reset
//   ena         in  : Tiny Tapeout enable (ignored)
//   ui_in[7:0]  in  : [0] start, [1] serial data, [4:2] mux select,
//                     [5] manual-mux enable, [7:6] unused
//   uo_out[7:0] out : Y, or the manual-mux selection
//   uio_in[7:0] in  : unused
//   uio_out[7:0]out : {4'b0, N, V, Z, C}
//   uio_oe[7:0] out : constant 8'h0F (flag pins driven)
// ---------------------------------------------------------------------------
module cpu_fabianp1704 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import cpu_fabianp1704_pkg::*;

  logic       start_s;
  logic       sdata_s;
  logic [2:0] mux_sel_s;
  logic       mux_en_s;
  logic       unused_s;

  logic [2:0] state_r;
  logic [4:0] bit_cnt_r;
  logic       last_bit_s;
  logic [7:0] a_sh_r;
  logic [7:0] b_sh_r;
  logic [3:0] op_r;
  logic [7:0] y_r;
  flags_t     flags_r;
  logic [7:0] reg_a_r;
  logic [7:0] reg_x_r;
  logic [7:0] pc_r;

  logic [7:0] alu_y_s;
  logic       alu_c_s;
  logic       alu_z_s;
  logic       alu_v_s;
  logic       alu_n_s;
  logic [7:0] mux_s;

  assign start_s   = ui_in[0];
  assign sdata_s   = ui_in[1];
  assign mux_sel_s = ui_in[4:2];
  assign mux_en_s  = ui_in[5];
  assign unused_s  = &{1'b0, ena, uio_in, ui_in[7:6]};

  alu8 u_alu (
    .a  (a_sh_r),
    .b  (b_sh_r),
    .op (op_r),
    .y  (alu_y_s),
    .c  (alu_c_s),
    .z  (alu_z_s),
    .v  (alu_v_s),
    .n  (alu_n_s)
  );

  // Last serial bit of the field currently being loaded
  always_comb begin
    last_bit_s = 1'b0;
    case (state_r)
      ST_LOAD_A, ST_LOAD_B: last_bit_s = (bit_cnt_r == LAST_BIT_DATA);
      ST_LOAD_OP:           last_bit_s = (bit_cnt_r == LAST_BIT_OP);
      default:              last_bit_s = 1'b0;
    endcase
  end

  // Transaction sequencer and serial bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 5'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          bit_cnt_r <= 5'd0;
          if (start_s) begin
            state_r <= ST_LOAD_A;
          end
        end
        ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: begin
          if (last_bit_s) begin
            bit_cnt_r <= 5'd0;
            case (state_r)
              ST_LOAD_A: state_r <= ST_LOAD_B;
              ST_LOAD_B: state_r <= ST_LOAD_OP;
              default:   state_r <= ST_EXEC;
            endcase
          end else begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end
        end
        ST_EXEC: state_r <= ST_WB;
        ST_WB:   state_r <= ST_IDLE;
        default: begin
          state_r   <= ST_IDLE;
          bit_cnt_r <= 5'd0;
        end
      endcase
    end
  end

  // Serial shift registers for operands and opcode (MSB arrives first)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r <= 8'h00;
      b_sh_r <= 8'h00;
      op_r   <= 4'h0;
    end else begin
      case (state_r)
        ST_LOAD_A:  a_sh_r <= {a_sh_r[6:0], sdata_s};
        ST_LOAD_B:  b_sh_r <= {b_sh_r[6:0], sdata_s};
        ST_LOAD_OP: op_r   <= {op_r[2:0], sdata_s};
        default: begin
          a_sh_r <= a_sh_r;
          b_sh_r <= b_sh_r;
          op_r   <= op_r;
        end
      endcase
    end
  end

  // Result and flag capture in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r     <= 8'h00;
      flags_r <= '0;
    end else if (state_r == ST_EXEC) begin
      y_r       <= alu_y_s;
      flags_r.n <= alu_n_s;
      flags_r.v <= alu_v_s;
      flags_r.z <= alu_z_s;
      flags_r.c <= alu_c_s;
    end
  end

  // Architectural register write-back and operation counter in WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_a_r <= 8'h00;
      reg_x_r <= 8'h00;
      pc_r    <= 8'h00;
    end else if (state_r == ST_WB) begin
      if (op_writes_a(op_r)) begin
        reg_a_r <= y_r;
      end
      if (op_writes_x(op_r)) begin
        reg_x_r <= y_r;
      end
      pc_r <= pc_r + 8'd1;
    end
  end

  // Debug-mux source selection
  always_comb begin
    mux_s = 8'h00;
    case (mux_sel_s)
      MUX_SELECT_ALU_Y: mux_s = y_r;
      MUX_SELECT_REG_A: mux_s = reg_a_r;
      MUX_SELECT_REG_B: mux_s = reg_x_r;
      MUX_SELECT_OP:    mux_s = {4'b0000, op_r};
      MUX_SELECT_PC:    mux_s = pc_r;
      MUX_SELECT_NONE:  mux_s = 8'h00;
      default:          mux_s = 8'h00;
    endcase
  end

  // Dedicated output: Y normally, debug mux when enabled (no clock delay)
  always_comb begin
    uo_out = y_r;
    if (mux_en_s) begin
      uo_out = mux_s;
    end else begin
      uo_out = y_r;
    end
  end

  assign uio_out = {4'b0000, flags_r};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_cpu_fabianp1704.sv
// ---------------------------------------------------------------------------
// tb_cpu_fabianp1704
// Self-checking bench for cpu_fabianp1704: directed cases with constant
// expectations plus randomized transactions checked against an arithmetic
// reference model of the ALU and register file.
// ---------------------------------------------------------------------------
module tb_cpu_fabianp1704;

  logic       clk_tb = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic       start, sdata, mux_en;
  logic [2:0] sel;
  logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_a, m_x, m_pc, m_op, m_y, m_flags;
  logic [7:0] y_exec, f_exec;

  assign ui_in  = {2'b00, mux_en, sel, sdata, start};
  assign uio_in = 8'h00;

  always #5 clk_tb = ~clk_tb;

  cpu_fabianp1704 dut (
    .clk     (clk_tb),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Reference ALU from the arithmetic rules; flags = N*8 + V*4 + Z*2 + C
  function automatic int model_alu(input int a, input int b, input int op,
                                   output int flags);
    int y, c, v, sa, sb;
    bit valid;
    c = 0; v = 0; valid = 1'b1; y = 0;
    sa = (a > 127) ? a - 256 : a;
    sb = (b > 127) ? b - 256 : b;
    case (op)
      0: begin y = (a + b) % 256; c = (a + b > 255) ? 1 : 0;
               v = ((sa + sb) > 127 || (sa + sb) < -128) ? 1 : 0; end
      1: begin y = (a - b + 256) % 256; c = (a < b) ? 1 : 0;
               v = ((sa - sb) > 127 || (sa - sb) < -128) ? 1 : 0; end
      2: y = a & b;
      3: y = a | b;
      4: y = a ^ b;
      5: y = a;
      6: y = b;
      7: begin y = (a * 2) % 256; c = (a >= 128) ? 1 : 0; end
      8: begin y = a / 2; c = a % 2; end
      9: y = a;
      10: y = b;
      11: begin y = (a + 1) % 256; c = (a == 255) ? 1 : 0; v = (a == 127) ? 1 : 0; end
      12: begin y = (a + 255) % 256; c = (a == 0) ? 1 : 0; v = (a == 128) ? 1 : 0; end
      default: begin y = 0; valid = 1'b0; end
    endcase
    flags = ((y >= 128) ? 8 : 0) + v * 4 + ((valid && y == 0) ? 2 : 0) + c;
    return y;
  endfunction

  task automatic model_reset();
    m_a = 0; m_x = 0; m_pc = 0; m_op = 0; m_y = 0; m_flags = 0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; sdata = 1'b0; mux_en = 1'b0; sel = 3'd0;
    repeat (2) @(negedge clk_tb);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one full transaction starting now (caller sits at a negedge);
  // returns at the negedge after WB so a following call starts at S+23.
  task automatic run_op(input int a, input int b, input int op, input bit hold);
    logic [7:0] av, bv;
    logic [3:0] ov;
    int y, f;
    av = a[7:0]; bv = b[7:0]; ov = op[3:0];
    start = 1'b1;
    @(negedge clk_tb);
    for (int i = 7; i >= 0; i--) begin
      start = hold; sdata = av[i]; @(negedge clk_tb);
    end
    for (int i = 7; i >= 0; i--) begin
      start = hold; sdata = bv[i]; @(negedge clk_tb);
    end
    for (int i = 3; i >= 0; i--) begin
      start = hold; sdata = ov[i]; @(negedge clk_tb);
    end
    start = 1'b0; sdata = 1'b0;
    @(negedge clk_tb);
    y_exec = uo_out;
    f_exec = uio_out;
    @(negedge clk_tb);
    y = model_alu(a, b, op, f);
    m_y = y; m_flags = f; m_op = op;
    if (op == 6 || op == 9) m_x = y;
    else if (op <= 12) m_a = y;
    m_pc = (m_pc + 1) % 256;
  endtask

  task automatic test_reset();
    int exp_sel [5] = '{0, 0, 0, 0, 0};
    rst_n = 1'b0; start = 1'b0; sdata = 1'b0; mux_en = 1'b0; sel = 3'd0;
    #1;
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_during: uo_out=%0d uio_out=%0d required 0/0", uo_out, uio_out);
    end
    repeat (2) @(negedge clk_tb);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk_tb);
    tests++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h0F) begin
      fails++;
      $display("FAIL reset_after: uo_out=%0d uio_out=%0d uio_oe=%h required 0/0/0f",
               uo_out, uio_out, uio_oe);
    end
    mux_en = 1'b1;
    for (int s = 0; s < 5; s++) begin
      sel = s[2:0];
      #1;
      tests++;
      if (uo_out !== exp_sel[s][7:0]) begin
        fails++;
        $display("FAIL reset_mux_sel%0d: got %0d required %0d", s, uo_out, exp_sel[s]);
      end
    end
    mux_en = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_flags();
    int ta [10] = '{11, 127, 255, 200, 0, 0, 255, 128, 1, 0};
    int tb [10] = '{15, 1,   1,   150, 1, 0, 0,   0,   0, 0};
    int to [10] = '{0,  0,   0,   1,   1, 12, 11, 7,   8, 14};
    int ty [10] = '{26, 128, 0,   50,  255, 255, 0, 0,  0, 0};
    int tf [10] = '{0,  12,  3,   0,   9,   9,   3, 3,  3, 0};
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      run_op(ta[i], tb[i], to[i], 1'b0);
      tests++;
      if (y_exec !== ty[i][7:0] || f_exec !== tf[i][7:0]) begin
        fails++;
        $display("FAIL flags_exec%0d op%0d: y=%0d flags=%0d required y=%0d flags=%0d",
                 i, to[i], y_exec, f_exec, ty[i], tf[i]);
      end
      tests++;
      if (uo_out !== ty[i][7:0] || uio_out !== tf[i][7:0]) begin
        fails++;
        $display("FAIL flags_wb%0d op%0d: y=%0d flags=%0d required y=%0d flags=%0d",
                 i, to[i], uo_out, uio_out, ty[i], tf[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ty [3] = '{15, 5, 5};
    apply_reset();
    run_op(10, 5, 0, 1'b1);
    tests++;
    if (uo_out !== ty[0][7:0]) begin
      fails++; $display("FAIL b2b_add: got %0d required %0d", uo_out, ty[0]);
    end
    run_op(10, 5, 1, 1'b1);
    tests++;
    if (uo_out !== ty[1][7:0]) begin
      fails++; $display("FAIL b2b_sub: got %0d required %0d", uo_out, ty[1]);
    end
    run_op(6, 3, 4, 1'b0);
    tests++;
    if (uo_out !== ty[2][7:0]) begin
      fails++; $display("FAIL b2b_xor: got %0d required %0d", uo_out, ty[2]);
    end
    mux_en = 1'b1; sel = 3'd4; #1;
    tests++;
    if (uo_out !== 8'd3) begin
      fails++; $display("FAIL b2b_pc: got %0d required 3", uo_out);
    end
    mux_en = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_regfile();
    int sa [4] = '{12, 12, 12, 77};
    int sb [4] = '{34, 34, 34, 0};
    int so [4] = '{5, 6, 9, 5};
    int ea [4] = '{12, 12, 12, 77};
    int ex [4] = '{0, 34, 12, 12};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      run_op(sa[i], sb[i], so[i], 1'b0);
      mux_en = 1'b1; sel = 3'd1; #1;
      tests++;
      if (uo_out !== ea[i][7:0]) begin
        fails++; $display("FAIL regfile%0d_a: got %0d required %0d", i, uo_out, ea[i]);
      end
      sel = 3'd2; #1;
      tests++;
      if (uo_out !== ex[i][7:0]) begin
        fails++; $display("FAIL regfile%0d_x: got %0d required %0d", i, uo_out, ex[i]);
      end
      mux_en = 1'b0;
      @(negedge clk_tb);
    end
  endtask

  task automatic test_mux();
    int exp_sel [8] = '{11, 11, 0, 5, 1, 0, 0, 0};
    apply_reset();
    run_op(11, 3, 5, 1'b0);
    mux_en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      sel = s[2:0]; #1;
      tests++;
      if (uo_out !== exp_sel[s][7:0]) begin
        fails++; $display("FAIL mux_sel%0d: got %0d required %0d", s, uo_out, exp_sel[s]);
      end
    end
    mux_en = 1'b0; #1;
    tests++;
    if (uo_out !== 8'd11) begin
      fails++; $display("FAIL mux_off: got %0d required 11", uo_out);
    end
    @(negedge clk_tb);
  endtask

  task automatic test_mid_reset();
    apply_reset();
    run_op(50, 0, 5, 1'b0);
    start = 1'b1;
    @(negedge clk_tb);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sdata = 1'($urandom_range(0, 1)); @(negedge clk_tb);
    end
    rst_n = 1'b0; mux_en = 1'b1; sel = 3'd1; #1;
    tests++;
    if (uo_out !== 8'd0) begin
      fails++; $display("FAIL midreset_a: got %0d required 0", uo_out);
    end
    sel = 3'd4; #1;
    tests++;
    if (uo_out !== 8'd0) begin
      fails++; $display("FAIL midreset_pc: got %0d required 0", uo_out);
    end
    mux_en = 1'b0; sdata = 1'b0;
    @(negedge clk_tb);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk_tb);
    run_op(0, 9, 6, 1'b0);
    mux_en = 1'b1; sel = 3'd2; #1;
    tests++;
    if (uo_out !== 8'd9) begin
      fails++; $display("FAIL midreset_after_x: got %0d required 9", uo_out);
    end
    sel = 3'd4; #1;
    tests++;
    if (uo_out !== 8'd1) begin
      fails++; $display("FAIL midreset_after_pc: got %0d required 1", uo_out);
    end
    mux_en = 1'b0;
    @(negedge clk_tb);
  endtask

  task automatic test_random();
    int a, b, op;
    bit hold;
    for (int n = 0; n < 40; n++) begin
      a = $urandom_range(0, 255);
      b = $urandom_range(0, 255);
      op = $urandom_range(0, 15);
      hold = 1'($urandom_range(0, 1));
      run_op(a, b, op, hold);
      tests++;
      if (y_exec !== m_y[7:0] || uo_out !== m_y[7:0]) begin
        fails++;
        $display("FAIL rand%0d_y op%0d a=%0d b=%0d: exec=%0d wb=%0d required %0d",
                 n, op, a, b, y_exec, uo_out, m_y);
      end
      tests++;
      if (uio_out !== m_flags[7:0]) begin
        fails++;
        $display("FAIL rand%0d_flags op%0d a=%0d b=%0d: got %0d required %0d",
                 n, op, a, b, uio_out, m_flags);
      end
      mux_en = 1'b1; sel = 3'd1; #1;
      tests++;
      if (uo_out !== m_a[7:0]) begin
        fails++; $display("FAIL rand%0d_a: got %0d required %0d", n, uo_out, m_a);
      end
      sel = 3'd2; #1;
      tests++;
      if (uo_out !== m_x[7:0]) begin
        fails++; $display("FAIL rand%0d_x: got %0d required %0d", n, uo_out, m_x);
      end
      sel = 3'd3; #1;
      tests++;
      if (uo_out !== m_op[7:0]) begin
        fails++; $display("FAIL rand%0d_op: got %0d required %0d", n, uo_out, m_op);
      end
      sel = 3'd4; #1;
      tests++;
      if (uo_out !== m_pc[7:0]) begin
        fails++; $display("FAIL rand%0d_pc: got %0d required %0d", n, uo_out, m_pc);
      end
      mux_en = 1'b0;
      @(negedge clk_tb);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_flags();
    test_back_to_back();
    test_regfile();
    test_mux();
    test_mid_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_fabianp1704.md
# cpu_fabianp1704

Tiny Tapeout top-level for a small 8-bit accumulator CPU with a bit-serial front end. After a start pulse, the block shifts in operand A (8 bits), operand B (8 bits) and a 4-bit opcode on one pin. It executes the opcode in an ALU and updates two architectural registers (A, X) and an operation counter (PC). The registered result appears on the dedicated outputs and the flags appear on the bidirectional pins. A manual mux exposes internal state for debug.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ena` in 1: Tiny Tapeout enable; ignored.
- `ui_in` in 8: [0] start; [1] serial data; [4:2] mux select; [5] manual-mux enable; [7:6] unused.
- `uo_out` out 8: result (Y) or the manual-mux selection.
- `uio_in` in 8: unused.
- `uio_out` out 8: [0] C, [1] Z, [2] V, [3] N; [7:4] = 0.
- `uio_oe` out 8: constant 8'h0F.

## Operation
- FSM states: IDLE, LOAD_A, LOAD_B, LOAD_OP, EXEC, WB.
  - IDLE → LOAD_A when start=1 is sampled; start is ignored in all other states.
  - LOAD_A: 8 bits. LOAD_B: 8 bits. LOAD_OP: 4 bits.
  - In each LOAD state, one bit of ui_in[1] is shifted in per edge, MSB first; a 5-bit bit counter controls the length.
  - LOAD_OP → EXEC → WB → IDLE.
- EXEC: the combinational ALU result and flags are latched into the Y and flag registers.
- WB: register writes occur and PC increments by 1 (8-bit, wraps 255→0).
- Opcodes, Y result, and register write:
  - 0 ADD: Y=a+b, A:=Y.
  - 1 SUB: Y=a-b, A:=Y.
  - 2 AND, 3 OR, 4 XOR: A:=Y.
  - 5 PASS_A: Y=a, A:=Y.
  - 6 PASS_B: Y=b, X:=Y.
  - 7 SHL: Y=a<<1, A:=Y.
  - 8 SHR: Y=a>>1 (logical), A:=Y.
  - 9 MOVE_XA: Y=a, X:=Y.
  - 10 MOVE_AX: Y=b, A:=Y.
  - 11 INC: Y=a+1, A:=Y.
  - 12 DEC: Y=a-1, A:=Y.
  - 13–15: Y=0, all flags 0, no register write; PC still increments.
- Flags (all arithmetic modulo 256):
  - Z = (Y==0). N = Y[7].
  - ADD: C = carry-out, V = signed overflow.
  - SUB: C = borrow (a<b), V = signed overflow.
  - INC: C = (a==255), V = (a==127).
  - DEC: C = (a==0), V = (a==128).
  - SHL: C = a[7]. SHR: C = a[0]. V = 0 for both.
  - Logic, pass and move ops: C = 0, V = 0.
- Output mux:
  - ui_in[5]=0: uo_out = Y.
  - ui_in[5]=1: uo_out is selected by ui_in[4:2]: 0 ALU_Y, 1 REG_A, 2 REG_X, 3 OP ({4'b0, op}), 4 PC, 5–7 NONE (0).
  - The mux is combinational; select changes are visible with no clock delay.
- Y, flags, A, X, op and PC hold their values until the next operation overwrites them.

## Timing
- Reset value of all state (A, X, Y, flags, PC, shift registers, op, counter) is 0. FSM resets to IDLE, so uo_out=0 and uio_out=0 during and after reset.
- Let edge S be the edge that samples start=1:
  - Edges S+1..S+8 sample A[7..0].
  - Edges S+9..S+16 sample B[7..0].
  - Edges S+17..S+20 sample op[3..0].
  - Edge S+21 (EXEC) updates Y and flags; they are visible on outputs from that edge.
  - Edge S+22 (WB) updates A/X and PC; the FSM is back in IDLE after this edge.
  - The earliest next start is sampled at S+23.
- Start held high for multiple cycles: only the first sample in IDLE counts; later samples occur in LOAD states and are ignored.
- Reset asserted mid-operation aborts immediately: FSM returns to IDLE, all registers clear, and there is no partial write.

## Structure
- Shared package/header holds:
  - opcode constants (OP_ADD=0 … OP_DEC=12);
  - mux-select constants (MUX_SELECT_ALU_Y=0, REG_A=1, REG_B=2, OP=3, PC=4, NONE=5);
  - FSM state encodings.
- One natural sub-module: `alu8`, purely combinational. Inputs a[7:0], b[7:0], op[3:0]; outputs y[7:0], c, z, v, n.
- Top-level holds the FSM, shift registers, A/X regfile, PC and output mux.

## Test plan
- Reset: after reset, uo_out=0 and flags=0. With manual mux, PC=0, REG_A=0, REG_X=0.
- ADD 11+15 → uo_out=26, flags 0000. ADD 127+1 → 128, V=1, N=1. ADD 255+1 → 0, C=1, Z=1.
- SUB 200-150 → 50. SUB 0-1 → 255, C=1, N=1. DEC 0 → 255, C=1. INC 255 → 0, C=1, Z=1. SHL 128 → 0, C=1, Z=1. SHR 1 → 0, C=1, Z=1.
- Back-to-back without reset: ADD(10,5)=15, then SUB(10,5)=5, then XOR(6,3)=5. PC reads 3 afterwards.
- Regfile sequence, each step checked via the manual mux:
  - PASS_A(12,34), then PASS_B(12,34) → REG_A=12, REG_X=34.
  - MOVE_XA(12,34) → REG_X=12, REG_A=12.
  - PASS_A(77,0) → REG_A=77, REG_X=12.
- Manual mux after PASS_A(11,3) from reset: REG_A=11, REG_X=0, ALU_Y=11, OP=5, PC=1, NONE=0. Deasserting ui_in[5] restores uo_out=11.
